// File: rtl/tqvp_sprite_engine.sv
// TinyQV peripheral: up to four 8-pixel-wide sprites over a background colour, with a
// staging/active object table swapped on vsync. Define SPRITE_MIRROR_EN for per-sprite horizontal flip.
module tqvp_sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_H    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        visible,
  input  logic        vsync,
  output logic [5:0]  rgb,
  output logic        user_interrupt
);

`ifdef SPRITE_MIRROR_EN
  localparam logic [31:0] OBJ_MASK = 32'hC3FF_FFFF;
`else
  localparam logic [31:0] OBJ_MASK = 32'h83FF_FFFF;
`endif

  typedef struct packed {
    logic       en;
`ifdef SPRITE_MIRROR_EN
    logic       flip;
`endif
    logic [5:0] colour;
    logic [9:0] y;
    logic [9:0] x;
  } obj_t;

  logic [31:0] stage_word [NUM_SPRITES];
  obj_t        active_obj [NUM_SPRITES];
  logic [7:0]  bitmap     [NUM_SPRITES][8];
  logic [5:0]  bg_colour;
  logic        commit_pending;
  logic        irq_flag;
  logic [7:0]  frame_count;
  logic        vsync_q;

  logic        wr_ok;
  logic [31:0] lane_mask;
  logic [31:0] wr_data;
  logic [3:0]  word_idx;
  logic        ctrl_wr;
  logic        irq_clr;
  logic        do_swap;
  logic [31:0] rd_word;
  logic [5:0]  hit_colour;
  logic [5:0]  pix_rgb;
  logic [2:0]  col;
  logic [2:0]  row;
  logic [2:0]  bit_idx;

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_flag;
  assign do_swap        = vsync & ~vsync_q & commit_pending;

  // Write data is shifted onto its byte lanes; misaligned accesses are dropped.
  always_comb begin
    wr_ok     = 1'b0;
    lane_mask = '0;
    case (data_write_n)
      2'b00: begin
        wr_ok     = 1'b1;
        lane_mask = 32'h0000_00FF << {address[1:0], 3'b000};
      end
      2'b01: begin
        wr_ok     = ~address[0];
        lane_mask = 32'h0000_FFFF << {address[1:0], 3'b000};
      end
      2'b10: begin
        wr_ok     = (address[1:0] == 2'b00);
        lane_mask = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
    wr_data  = data_in << {address[1:0], 3'b000};
    word_idx = address[5:2];
    ctrl_wr  = wr_ok && (word_idx == 4'd4) && lane_mask[0];
    irq_clr  = wr_ok && (address == 6'h18) && data_in[0];
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (word_idx == 4'(i)) rd_word = stage_word[i];
      for (int r = 0; r < 8; r++)
        if (word_idx == 4'(8 + 2*i + r/4)) rd_word[8*(r%4) +: 8] = bitmap[i][r];
    end
    if (word_idx == 4'd4) rd_word = {25'd0, bg_colour, commit_pending};
    if (word_idx == 4'd5) rd_word = {22'd0, frame_count, irq_flag, commit_pending};
    data_out = (data_read_n != 2'b11) ? rd_word : 32'd0;
  end

  // Walk sprites from highest to lowest index so the lowest opaque hit overrides.
  always_comb begin
    hit_colour = bg_colour;
    col        = '0;
    row        = '0;
    bit_idx    = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      col     = pix_x[2:0] - active_obj[i].x[2:0];
      row     = pix_y[2:0] - active_obj[i].y[2:0];
      bit_idx = 3'd7 - col;
`ifdef SPRITE_MIRROR_EN
      if (active_obj[i].flip) bit_idx = col;
`endif
      if (active_obj[i].en &&
          (pix_x >= active_obj[i].x) &&
          ({1'b0, pix_x} < {1'b0, active_obj[i].x} + 11'd8) &&
          (pix_y >= active_obj[i].y) &&
          ({1'b0, pix_y} < {1'b0, active_obj[i].y} + 11'(SPRITE_H)) &&
          bitmap[i][row][bit_idx])
        hit_colour = active_obj[i].colour;
    end
    pix_rgb = visible ? hit_colour : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        stage_word[i] <= '0;
        active_obj[i] <= '0;
        for (int r = 0; r < 8; r++) bitmap[i][r] <= '0;
      end
      bg_colour      <= '0;
      commit_pending <= 1'b0;
      irq_flag       <= 1'b0;
      frame_count    <= '0;
      vsync_q        <= 1'b0;
      rgb            <= '0;
    end else begin
      vsync_q <= vsync;
      rgb     <= pix_rgb;
      // Swap copies the pre-write staging value; a coincident write lands in staging only.
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (do_swap) begin
          active_obj[i].en     <= stage_word[i][31];
`ifdef SPRITE_MIRROR_EN
          active_obj[i].flip   <= stage_word[i][30];
`endif
          active_obj[i].colour <= stage_word[i][25:20];
          active_obj[i].y      <= stage_word[i][19:10];
          active_obj[i].x      <= stage_word[i][9:0];
        end
        if (wr_ok && (word_idx == 4'(i)))
          stage_word[i] <= ((stage_word[i] & ~lane_mask) | (wr_data & lane_mask)) & OBJ_MASK;
        for (int r = 0; r < SPRITE_H; r++)
          if (wr_ok && (word_idx == 4'(8 + 2*i + r/4)) && lane_mask[8*(r%4)])
            bitmap[i][r] <= wr_data[8*(r%4) +: 8];
      end
      if (ctrl_wr) bg_colour <= wr_data[6:1];
      if (ctrl_wr && wr_data[0]) commit_pending <= 1'b1;
      else if (do_swap)          commit_pending <= 1'b0;
      if (do_swap) begin
        irq_flag    <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end else if (irq_clr) begin
        irq_flag <= 1'b0;
      end
    end
  end

endmodule
